// File: rtl/dmac_pkg.sv
// dmac_pkg: DMAC register map, field bit positions and AHB-Lite HTRANS codes shared by the register block and the engine
package dmac_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [5:0] OFF_SADDR = 6'h00;
  localparam logic [5:0] OFF_DADDR = 6'h04;
  localparam logic [5:0] OFF_SIZE  = 6'h08;
  localparam logic [5:0] OFF_INC   = 6'h0C;
  localparam logic [5:0] OFF_BLK   = 6'h10;
  localparam logic [5:0] OFF_CTRL  = 6'h14;
  localparam logic [5:0] OFF_STAT  = 6'h18;
  localparam logic [5:0] OFF_IM    = 6'h1C;
  localparam logic [5:0] OFF_ICRA  = 6'h20;
  localparam logic [5:0] OFF_ICRV  = 6'h24;
  localparam int SRC_LSB         = 0;
  localparam int DST_LSB         = 8;
  localparam int BLK_BSIZE_LSB   = 0;
  localparam int BLK_BCOUNT_LSB  = 8;
  localparam int CTRL_START      = 0;
  localparam int CTRL_WFI        = 1;
  localparam int CTRL_IRQSRC_LSB = 4;
  localparam int STAT_BUSY       = 0;
  localparam int STAT_DONE       = 1;
  localparam int IM_DONE         = 0;
endpackage

// File: rtl/ahbl_addr_phase.sv
// ahbl_addr_phase: captures an accepted AHB-Lite address phase so the next cycle can act as its data phase
module ahbl_addr_phase
  import dmac_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel,
  input  logic       ready,
  input  logic [1:0] trans,
  input  logic [3:0] addr,
  input  logic       write,
  output logic       valid,
  output logic       wr,
  output logic [5:0] off
);
  logic take;
  assign take = sel && ready && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);
  // Latch word offset and direction of an accepted slot; reset drops any pending data phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      wr    <= 1'b0;
      off   <= '0;
    end else if (ready) begin
      valid <= take;
      if (take) begin
        wr  <= write;
        off <= {addr, 2'b00};
      end
    end
  end
endmodule

// File: rtl/dmac_regs.sv
// dmac_regs: AHB-Lite register block for the DMA engine; define DMAC_IRQ_EN to build the IM register and irq output
module dmac_regs
  import dmac_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [31:0] saddr,
  output logic [31:0] daddr,
  output logic [2:0]  ssize,
  output logic [2:0]  dsize,
  output logic [2:0]  sinc,
  output logic [2:0]  dinc,
  output logic [7:0]  bsize,
  output logic [7:0]  bcount,
  output logic        wfi,
  output logic [2:0]  irqsrc,
  output logic [31:0] icra,
  output logic [31:0] icrv,
  output logic        start,
  input  logic        done,
  input  logic        busy,
  output logic        irq
);
  logic       valid, write, wr, cfg_wr, stat_done, im;
  logic [5:0] off;
  logic       unused;
  assign unused    = ^{HSIZE, HADDR[31:6], HADDR[1:0]};
  assign HREADYOUT = 1'b1;
  ahbl_addr_phase u_addr_phase (
    .clk  (HCLK),
    .rst_n(HRESETn),
    .sel  (HSEL),
    .ready(HREADY),
    .trans(HTRANS),
    .addr (HADDR[5:2]),
    .write(HWRITE),
    .valid(valid),
    .wr   (write),
    .off  (off)
  );
  assign wr     = valid && write;
  assign cfg_wr = wr && !busy;
  // Engine configuration is frozen while the engine runs; start fires one cycle after an accepted go
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      saddr  <= '0;
      daddr  <= '0;
      ssize  <= '0;
      dsize  <= '0;
      sinc   <= '0;
      dinc   <= '0;
      bsize  <= '0;
      bcount <= '0;
      wfi    <= 1'b0;
      irqsrc <= '0;
      icra   <= '0;
      icrv   <= '0;
      start  <= 1'b0;
    end else begin
      if (cfg_wr && off == OFF_SADDR) saddr <= HWDATA;
      if (cfg_wr && off == OFF_DADDR) daddr <= HWDATA;
      if (cfg_wr && off == OFF_SIZE) begin
        ssize <= HWDATA[SRC_LSB +: 3];
        dsize <= HWDATA[DST_LSB +: 3];
      end
      if (cfg_wr && off == OFF_INC) begin
        sinc <= HWDATA[SRC_LSB +: 3];
        dinc <= HWDATA[DST_LSB +: 3];
      end
      if (cfg_wr && off == OFF_BLK) begin
        bsize  <= HWDATA[BLK_BSIZE_LSB +: 8];
        bcount <= HWDATA[BLK_BCOUNT_LSB +: 8];
      end
      if (cfg_wr && off == OFF_CTRL) begin
        wfi    <= HWDATA[CTRL_WFI];
        irqsrc <= HWDATA[CTRL_IRQSRC_LSB +: 3];
      end
      if (cfg_wr && off == OFF_ICRA) icra <= HWDATA;
      if (cfg_wr && off == OFF_ICRV) icrv <= HWDATA;
      start <= cfg_wr && off == OFF_CTRL && HWDATA[CTRL_START];
    end
  end
  // Sticky completion flag: a done pulse outranks a simultaneous write-one-to-clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) stat_done <= 1'b0;
    else          stat_done <= done || (stat_done && !(wr && off == OFF_STAT && HWDATA[STAT_DONE]));
  end
`ifdef DMAC_IRQ_EN
  // Interrupt mask stays writable while busy so software can react to a running transfer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                 im <= 1'b0;
    else if (wr && off == OFF_IM) im <= HWDATA[IM_DONE];
  end
`else
  assign im = 1'b0;
`endif
  assign irq = stat_done && im;
  // Read mux for the data phase; writes and idle cycles return zero
  always_comb begin
    HRDATA = '0;
    if (valid && !write) begin
      case (off)
        OFF_SADDR: HRDATA = saddr;
        OFF_DADDR: HRDATA = daddr;
        OFF_SIZE:  HRDATA = {21'b0, dsize, 5'b0, ssize};
        OFF_INC:   HRDATA = {21'b0, dinc, 5'b0, sinc};
        OFF_BLK:   HRDATA = {16'b0, bcount, bsize};
        OFF_CTRL:  HRDATA = {25'b0, irqsrc, 2'b0, wfi, 1'b0};
        OFF_STAT:  HRDATA = {30'b0, stat_done, busy};
        OFF_IM:    HRDATA = {31'b0, im};
        OFF_ICRA:  HRDATA = icra;
        OFF_ICRV:  HRDATA = icrv;
        default:   HRDATA = '0;
      endcase
    end
  end
endmodule

// File: doc/dmac_regs.md
DMAC_REGS -- requirements
Module: dmac_regs

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have ports HCLK in 1, the single clock.
REQ-003 SHALL have HRESETn in 1; reset is asynchronous, active-low.
REQ-004 SHALL have AHB-Lite slave ports HSEL in 1, HADDR in 32, HTRANS in 2, HWRITE in 1, HSIZE in 3, HREADY in 1, HWDATA in 32, HRDATA out 32, HREADYOUT out 1.
REQ-005 SHALL have engine config outputs saddr 32, daddr 32, ssize 3, dsize 3, sinc 3, dinc 3, bsize 8, bcount 8, wfi 1, irqsrc 3, icra 32, icrv 32.
REQ-006 SHALL have engine control output start 1, a single-cycle go pulse.
REQ-007 SHALL have engine status inputs done 1 (single-cycle completion pulse) and busy 1 (level).
REQ-008 SHALL have output irq 1, the interrupt to the CPU.

Function
REQ-009 SHALL capture HADDR[5:2] and HWRITE when HSEL & HREADY & HTRANS[1]; the following cycle is the data phase.
REQ-010 SHALL drive HREADYOUT = 1 always (zero wait states).
REQ-011 SHALL use this map: 0x00 SADDR; 0x04 DADDR; 0x08 SIZE (ssize [2:0], dsize [10:8]); 0x0C INC (sinc [2:0], dinc [10:8]); 0x10 BLK (bsize [7:0], bcount [15:8]); 0x14 CTRL (start [0] WO, wfi [1], irqsrc [6:4]); 0x18 STAT (busy [0] RO, done [1] W1C); 0x1C IM (done-irq enable [0]); 0x20 ICRA; 0x24 ICRV.
REQ-012 SHALL write HWDATA fields into the captured register at the end of the data phase; unmapped offsets SHALL ignore writes and read 0.
REQ-013 SHALL return HRDATA from the captured offset during the data phase; unused bits read 0; CTRL[0] reads 0.
REQ-014 SHALL raise start for exactly one cycle, the cycle after a CTRL write with HWDATA[0]=1, only if busy=0 at that write; otherwise the start request is dropped.
REQ-015 SHALL ignore writes to SADDR..BLK, ICRA, ICRV and CTRL[6:1] while busy=1; IM and STAT remain writable.
REQ-016 SHALL set STAT.done on done=1; a STAT write with HWDATA[1]=1 clears it; on the same cycle, set wins.
REQ-017 SHALL drive irq = STAT.done & IM[0], combinationally from registers.
REQ-018 SHALL treat HSIZE as full-word; byte/halfword writes update the whole word (documented limitation).
REQ-019 SHALL discard a pending data phase if HRESETn asserts mid-transfer.

Reset
REQ-020 SHALL, on HRESETn low, clear all registers, the address-phase capture, start, irq and HRDATA to 0 immediately.
REQ-021 SHALL keep HREADYOUT = 1 during and after reset.

Configuration
REQ-022 SHALL, with DMAC_IRQ_EN defined, implement IM and irq per REQ-017.
REQ-023 SHALL, without DMAC_IRQ_EN, read IM as 0, ignore IM writes and tie irq to 0; STAT.done still works.

Structure
REQ-024 SHALL place register offsets, field bit positions and the HTRANS NONSEQ/IDLE constants in shared package dmac_pkg, also used by the engine.
REQ-025 SHALL use sub-module ahbl_addr_phase for address-phase capture; all else inline.

Verification
REQ-026 SHALL check: write 0x2000_0000 to 0x00, then read -> HRDATA 0x2000_0000; reads of 0x28 -> 0.
REQ-027 SHALL check: CTRL write 0x1 with busy=0 -> start high for exactly 1 cycle, next cycle low.
REQ-028 SHALL check: busy=1, write 0x1234 to 0x00 and 0x1 to CTRL -> SADDR unchanged, no start.
REQ-029 SHALL check: IM=1, done pulse -> STAT reads 0x2, irq=1; W1C 0x2 -> irq=0; W1C coincident with done -> STAT.done stays 1.
REQ-030 SHALL check: HRESETn low during a data phase of a write 0xFFFF_FFFF to 0x04 -> DADDR=0, irq=0, start=0 after reset.
